// File: rtl/pipe_pkg.sv
// Shared EX/MEM pipeline definitions: payload bundle layout and default widths.
// Used by pipe_stage_reg and sat_counter; pipe_stage_reg itself never looks inside the payload.
// Optional build macro consumed elsewhere: PIPE_STAGE_SKID_EN.
package pipe_pkg;

  // EX/MEM bundle as it travels between the execute and memory stages.
  typedef struct packed {
    logic        reg_write;
    logic [1:0]  result_src;
    logic        mem_write;
    logic [31:0] alu_result;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic [31:0] pc_plus4;
  } ex_mem_t;

  // Packed width of the full bundle; instances carrying ex_mem_t pass this as DATA_W.
  localparam int EX_MEM_W = $bits(ex_mem_t);

  // Historical default payload width of the stage register.
  localparam int PIPE_DATA_W_DFLT = 104;

  // Default width of the stall-cycle counter.
  localparam int STALL_CNT_W_DFLT = 16;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: counts cycles with inc=1 and sticks at all-ones.
// Latency: count reflects an inc one cycle after the edge that samples it.
// Backpressure: none; reset (synchronous, active-high) clears to zero.
module sat_counter
  import pipe_pkg::*;
#(
  parameter int CNT_W = STALL_CNT_W_DFLT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_cnt;

  assign count = r_cnt;

  // Increment on inc until every bit is set, then hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (inc && !(&r_cnt)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready register slice between EX and MEM, payload-agnostic.
// Latency: 1 cycle from acceptance into an empty stage to out_valid; 1 transfer/cycle sustained.
// Backpressure: default build holds 1 entry, in_ready = !out_valid | out_ready (combinational);
//   with PIPE_STAGE_SKID_EN a skid entry makes in_ready a pure register output (!skid valid).
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W_DFLT,
  parameter int CNT_W  = STALL_CNT_W_DFLT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              w_in_xfer;
  logic              w_out_xfer;
  logic              w_stall;
  logic              r_main_vld;
  logic [DATA_W-1:0] r_main_dat;

  assign out_valid  = r_main_vld;
  assign out_data   = r_main_dat;
  assign w_in_xfer  = in_valid & in_ready;
  assign w_out_xfer = r_main_vld & out_ready;
  assign w_stall    = r_main_vld & ~out_ready;

`ifdef PIPE_STAGE_SKID_EN
  logic              r_skid_vld;
  logic [DATA_W-1:0] r_skid_dat;

  // Only the skid register gates acceptance, so out_ready never reaches in_ready.
  assign in_ready = ~r_skid_vld;

  // Main entry: refill from skid first (older), else from the input, else drain.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_main_vld <= 1'b0;
      r_main_dat <= '0;
    end else if (flush) begin
      r_main_vld <= 1'b0;
    end else if (w_out_xfer) begin
      if (r_skid_vld) begin
        r_main_dat <= r_skid_dat;
      end else if (w_in_xfer) begin
        r_main_dat <= in_data;
      end else begin
        r_main_vld <= 1'b0;
      end
    end else if (w_in_xfer && !r_main_vld) begin
      r_main_vld <= 1'b1;
      r_main_dat <= in_data;
    end
  end

  // Skid entry: catches a payload accepted while main is stalled; empties when main moves.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_skid_vld <= 1'b0;
      r_skid_dat <= '0;
    end else if (flush || w_out_xfer) begin
      r_skid_vld <= 1'b0;
    end else if (w_in_xfer && r_main_vld) begin
      r_skid_vld <= 1'b1;
      r_skid_dat <= in_data;
    end
  end
`else
  // Single entry: accept whenever the held payload is absent or leaving this cycle.
  assign in_ready = ~r_main_vld | out_ready;

  // Load on input transfer (covers simultaneous dequeue), drain on a lone output transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_main_vld <= 1'b0;
      r_main_dat <= '0;
    end else if (flush) begin
      r_main_vld <= 1'b0;
    end else if (w_in_xfer) begin
      r_main_vld <= 1'b1;
      r_main_dat <= in_data;
    end else if (w_out_xfer) begin
      r_main_vld <= 1'b0;
    end
  end
`endif

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_stall),
    .count (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed table, hand sequences and random traffic vs a queue model.
// Two instances share stimulus: default counter width and a 4-bit counter for saturation.
// Build with PIPE_STAGE_SKID_EN defined to exercise the skid variant.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int W = EX_MEM_W;
`ifdef PIPE_STAGE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset, flush, in_valid, out_ready;
  logic [W-1:0] in_data;
  logic         in_ready, out_valid, in_ready4, out_valid4;
  logic [W-1:0] out_data, out_data4;
  logic [15:0]  stall_cnt;
  logic [3:0]   stall_cnt4;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(W), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .stall_cnt(stall_cnt));

  pipe_stage_reg #(.DATA_W(W), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready4),
    .in_data(in_data), .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
    .stall_cnt(stall_cnt4));

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: ordered queue of held payloads, last presented payload, stall counts.
  logic [W-1:0] mq[$];
  logic [W-1:0] m_last;
  int           m_st16, m_st4;
  bit           m_known = 1'b0;
  logic         s_irdy;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic model_irdy(input logic ordy);
    if (SKID) return mq.size() < 2;
    return (mq.size() == 0) || ordy;
  endfunction

  // One clock cycle: drive, check in_ready, advance model at the edge, check outputs.
  task automatic cyc(input logic r, input logic f, input logic iv,
                     input logic [W-1:0] id, input logic ordy);
    logic m_irdy, in_x, out_x, stl;
    reset = r; flush = f; in_valid = iv; in_data = id; out_ready = ordy;
    #1;
    s_irdy = in_ready;
    m_irdy = model_irdy(ordy);
    if (m_known) begin
      chk("in_ready", 128'(in_ready), 128'(m_irdy));
      chk("in_ready4", 128'(in_ready4), 128'(m_irdy));
    end
    in_x  = iv && m_irdy;
    out_x = (mq.size() > 0) && ordy;
    stl   = (mq.size() > 0) && !ordy;
    @(posedge clk);
    if (r) begin
      mq.delete(); m_last = '0; m_st16 = 0; m_st4 = 0; m_known = 1'b1;
    end else begin
      if (stl) begin
        if (m_st16 < 65535) m_st16++;
        if (m_st4 < 15) m_st4++;
      end
      if (f) mq.delete();
      else begin
        if (out_x) void'(mq.pop_front());
        if (in_x) mq.push_back(id);
      end
      if (mq.size() > 0) m_last = mq[0];
    end
    @(negedge clk);
    if (m_known) begin
      chk("out_valid", 128'(out_valid), 128'(mq.size() > 0));
      chk("out_data", 128'(out_data), 128'(m_last));
      chk("stall_cnt", 128'(stall_cnt), 128'(m_st16));
      chk("out_valid4", 128'(out_valid4), 128'(mq.size() > 0));
      chk("out_data4", 128'(out_data4), 128'(m_last));
      chk("stall_cnt4", 128'(stall_cnt4), 128'(m_st4));
    end
  endtask

  typedef struct {
    logic         r, f, iv, ordy;
    logic [W-1:0] id;
    bit           chk_irdy;
    logic         exp_irdy, exp_ovld;
    logic [W-1:0] exp_odat;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic iv, input logic [W-1:0] id,
                              input bit ci, input logic ei, input logic eo,
                              input logic [W-1:0] ed);
    vec_t v;
    v.r = r; v.f = 1'b0; v.iv = iv; v.id = id; v.ordy = 1'b1;
    v.chk_irdy = ci; v.exp_irdy = ei; v.exp_ovld = eo; v.exp_odat = ed;
    return v;
  endfunction

  initial begin
    vec_t         tbl[12];
    int           acc;
    logic [127:0] rnd;

    // Reset, single 0xA5 payload, bubble, then payloads 1..8 back to back.
    tbl[0] = mk(1'b1, 1'b0, '0,         1'b0, 1'b0, 1'b0, '0);
    tbl[1] = mk(1'b0, 1'b1, W'('hA5),   1'b1, 1'b1, 1'b1, W'('hA5));
    tbl[2] = mk(1'b0, 1'b0, '0,         1'b1, 1'b1, 1'b0, W'('hA5));
    for (int k = 1; k <= 8; k++)
      tbl[2+k] = mk(1'b0, 1'b1, W'(k),  1'b1, 1'b1, 1'b1, W'(k));
    tbl[11] = mk(1'b0, 1'b0, '0,        1'b1, 1'b1, 1'b0, W'(8));

    for (int i = 0; i < 12; i++) begin
      cyc(tbl[i].r, tbl[i].f, tbl[i].iv, tbl[i].id, tbl[i].ordy);
      if (tbl[i].chk_irdy) chk($sformatf("tbl%0d_in_ready", i), 128'(s_irdy), 128'(tbl[i].exp_irdy));
      chk($sformatf("tbl%0d_out_valid", i), 128'(out_valid), 128'(tbl[i].exp_ovld));
      chk($sformatf("tbl%0d_out_data", i), 128'(out_data), 128'(tbl[i].exp_odat));
    end

    // Five stall cycles while streaming: count accepts, stall cycles, order on release.
    cyc(1'b1, 1'b0, 1'b0, '0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, W'('h10), 1'b1);
    acc = int'(s_irdy);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b0, 1'b1, W'('h11 + i), 1'b0);
      acc += int'(s_irdy);
    end
    chk("stall_accepts", 128'(acc), SKID ? 128'd2 : 128'd1);
    chk("stall_cnt_5", 128'(stall_cnt), 128'd5);
    chk("stall_head", 128'(out_data), 128'h10);
    cyc(1'b0, 1'b0, 1'b0, '0, 1'b1);
    chk("release_vld", 128'(out_valid), 128'(SKID));
    chk("release_dat", 128'(out_data), SKID ? 128'h11 : 128'h10);
    cyc(1'b0, 1'b0, 1'b0, '0, 1'b1);
    chk("release_empty", 128'(out_valid), 128'd0);

    // Full stage flushed with a same-cycle input and output transfer.
    cyc(1'b1, 1'b0, 1'b0, '0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, W'('h21), 1'b0);
    if (SKID) cyc(1'b0, 1'b0, 1'b1, W'('h22), 1'b0);
    cyc(1'b0, 1'b1, 1'b1, W'('hDEAD), 1'b1);
    chk("flush_vld", 128'(out_valid), 128'd0);
    chk("flush_dat_held", 128'(out_data), 128'h21);
    chk("flush_stall", 128'(stall_cnt), SKID ? 128'd1 : 128'd0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 1'b0, '0, 1'b1);
      chk("post_flush_irdy", 128'(s_irdy), 128'd1);
      chk("post_flush_vld", 128'(out_valid), 128'd0);
    end

    // Saturation of the 4-bit counter, then reset together with flush.
    cyc(1'b1, 1'b0, 1'b0, '0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, W'('h31), 1'b1);
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0, 1'b0, '0, 1'b0);
    chk("sat4_15", 128'(stall_cnt4), 128'd15);
    chk("cnt16_20", 128'(stall_cnt), 128'd20);
    cyc(1'b0, 1'b0, 1'b0, '0, 1'b0);
    chk("sat4_hold", 128'(stall_cnt4), 128'd15);
    cyc(1'b1, 1'b1, 1'b1, W'('h99), 1'b1);
    chk("rst_vld", 128'(out_valid), 128'd0);
    chk("rst_dat", 128'(out_data), 128'd0);
    chk("rst_cnt", 128'(stall_cnt), 128'd0);
    chk("rst_cnt4", 128'(stall_cnt4), 128'd0);
    cyc(1'b0, 1'b0, 1'b0, '0, 1'b0);
    chk("rst_irdy", 128'(s_irdy), 128'd1);

    // Random traffic with occasional flush and reset, long stall bursts included.
    for (int i = 0; i < 600; i++) begin
      rnd = {$urandom, $urandom, $urandom, $urandom};
      cyc($urandom_range(0, 99) == 0, $urandom_range(0, 15) == 0,
          $urandom_range(0, 3) != 0, rnd[W-1:0],
          (i % 100) < 70 ? ($urandom_range(0, 2) != 0) : 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
